conv_controller: RTL and testbench

Control FSM that drives the control inputs of the convolution datapath (valid_in, pp1, oe, pp2) and consumes its get_1_pic_done / conv_1_filter_done flags. It accepts one IMG_W×IMG_H image from an upstream valid/ready source into the input FIFO, then streams the image through the 3×3 window and operator. It stores the (IMG_W-2)×(IMG_H-2) valid results in the output FIFO and drains them to a downstream consumer.

---
 rtl/conv_controller.sv | 183 ++++++++++++++++++
 tb/tb_conv_controller.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_controller.sv
// conv_controller: sequences one image through the convolution datapath.
// It loads the image into the input FIFO, streams it through the 3x3 window,
// pushes the valid results into the output FIFO, then drains them downstream.
module conv_controller #(
  parameter int unsigned IMG_W = 28,
  parameter int unsigned IMG_H = 28,
  parameter int unsigned LAT   = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic pixel_valid_i,
  output logic pixel_ready_o,
  input  logic get_1_pic_done,
  input  logic conv_1_filter_done,
  output logic valid_in,
  output logic pp1,
  output logic oe,
  output logic pp2,
  input  logic ready_i,
  output logic out_valid,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int unsigned N  = IMG_W * IMG_H;
  localparam int unsigned M  = (IMG_W - 2) * (IMG_H - 2);
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned FW = $clog2(LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]  r_ld_cnt;
  logic [CW-1:0]  r_pop_cnt;
  logic [CW-1:0]  r_row;
  logic [CW-1:0]  r_col;
  logic [CW-1:0]  r_push_cnt;
  logic [CW-1:0]  r_dr_cnt;
  logic [FW-1:0]  r_fl_cnt;
  logic [LAT-1:0] r_dl;
  logic           r_out_valid;
  logic           r_err;

  logic w_win_ok;
  logic w_dl_in;
  logic w_push;
  logic w_load_err;
  logic w_flush_end;
  logic w_flush_err;
  logic w_drain_pop;

  // A popped pixel completes a full 3x3 window once two rows and two columns precede it
  assign w_win_ok    = (r_row >= CW'(2)) && (r_col >= CW'(2));
  assign w_dl_in     = (r_state == S_STREAM) && w_win_ok;
  assign w_push      = r_dl[LAT-1];
  assign w_load_err  = (r_state == S_LOAD) && get_1_pic_done && (r_ld_cnt < CW'(N));
  assign w_flush_end = (r_state == S_FLUSH) && (r_fl_cnt == FW'(LAT - 1));
  // At FLUSH exit the final push is in flight, so the full flag must reflect only completed pushes
  assign w_flush_err = w_flush_end &&
                       (((r_push_cnt + CW'(w_push)) != CW'(M)) ||
                        (conv_1_filter_done != (r_push_cnt == CW'(M))));

  assign out_valid = r_out_valid;
  assign err       = r_err;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and FIFO control decode
  always_comb begin
    w_next        = r_state;
    pixel_ready_o = 1'b0;
    valid_in      = 1'b0;
    pp1           = 1'b0;
    oe            = 1'b0;
    pp2           = 1'b0;
    w_drain_pop   = 1'b0;
    done          = 1'b0;
    busy          = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LOAD;
      end
      S_LOAD: begin
        pixel_ready_o = 1'b1;
        valid_in      = pixel_valid_i;
        pp1           = 1'b1;
        if (w_load_err)                                    w_next = S_IDLE;
        else if (pixel_valid_i && (r_ld_cnt == CW'(N - 1))) w_next = S_STREAM;
      end
      S_STREAM: begin
        valid_in = 1'b1;
        oe       = w_push;
        pp2      = w_push;
        if (r_pop_cnt == CW'(N - 1)) w_next = S_FLUSH;
      end
      S_FLUSH: begin
        oe  = w_push;
        pp2 = w_push;
        if (w_flush_end) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        w_drain_pop = ready_i && (r_dr_cnt != CW'(M));
        oe          = w_drain_pop;
        if (r_dr_cnt == CW'(M)) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Counters, window delay line and registered out_valid
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ld_cnt    <= '0;
      r_pop_cnt   <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_push_cnt  <= '0;
      r_dr_cnt    <= '0;
      r_fl_cnt    <= '0;
      r_dl        <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_dl        <= LAT'({r_dl, w_dl_in});
      r_out_valid <= w_drain_pop;
      if (r_state == S_IDLE) r_push_cnt <= '0;
      else if (w_push)       r_push_cnt <= r_push_cnt + CW'(1);
      case (r_state)
        S_IDLE: begin
          r_ld_cnt  <= '0;
          r_pop_cnt <= '0;
          r_row     <= '0;
          r_col     <= '0;
          r_dr_cnt  <= '0;
          r_fl_cnt  <= '0;
        end
        S_LOAD: begin
          if (pixel_valid_i) r_ld_cnt <= r_ld_cnt + CW'(1);
        end
        S_STREAM: begin
          r_pop_cnt <= r_pop_cnt + CW'(1);
          if (r_col == CW'(IMG_W - 1)) begin
            r_col <= '0;
            r_row <= r_row + CW'(1);
          end else begin
            r_col <= r_col + CW'(1);
          end
        end
        S_FLUSH: r_fl_cnt <= r_fl_cnt + FW'(1);
        S_DRAIN: begin
          if (w_drain_pop) r_dr_cnt <= r_dr_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Sticky error flag, cleared when a new image is started
  always_ff @(posedge clk) begin
    if (reset)                            r_err <= 1'b0;
    else if ((r_state == S_IDLE) && start) r_err <= 1'b0;
    else if (w_load_err || w_flush_err)    r_err <= 1'b1;
  end

endmodule

// File: tb/tb_conv_controller.sv
// tb_conv_controller: randomized self-checking bench for conv_controller (5x5 image).
module tb_conv_controller;

  localparam int unsigned W    = 5;
  localparam int unsigned H    = 5;
  localparam int unsigned L    = 2;
  localparam int          N    = W * H;
  localparam int          M    = (W - 2) * (H - 2);
  localparam int          MAXC = 400;

  logic clk = 1'b0;
  logic reset, start, pixel_valid_i, pixel_ready_o;
  logic get_1_pic_done, conv_1_filter_done;
  logic valid_in, pp1, oe, pp2, ready_i, out_valid, busy, done, err;
  logic force_g, force_cd;

  int n_checks = 0;
  int n_pass   = 0;
  int in_cnt, out_cnt;

  bit pv [MAXC];
  bit rdy[MAXC];
  bit e_prdy[MAXC], e_vin[MAXC], e_pp1[MAXC], e_oe[MAXC], e_pp2[MAXC];
  bit e_ov[MAXC], e_busy[MAXC], e_done[MAXC], e_err[MAXC];

  always #5 clk = ~clk;

  conv_controller #(.IMG_W(W), .IMG_H(H), .LAT(L)) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .pixel_valid_i      (pixel_valid_i),
    .pixel_ready_o      (pixel_ready_o),
    .get_1_pic_done     (get_1_pic_done),
    .conv_1_filter_done (conv_1_filter_done),
    .valid_in           (valid_in),
    .pp1                (pp1),
    .oe                 (oe),
    .pp2                (pp2),
    .ready_i            (ready_i),
    .out_valid          (out_valid),
    .busy               (busy),
    .done               (done),
    .err                (err)
  );

  // Datapath FIFO occupancy, producing the full flags the controller consumes
  always @(posedge clk) begin
    if (reset) begin
      in_cnt  <= 0;
      out_cnt <= 0;
    end else begin
      if (valid_in) in_cnt  <= pp1 ? in_cnt + 1 : in_cnt - 1;
      if (oe)       out_cnt <= pp2 ? out_cnt + 1 : out_cnt - 1;
    end
  end
  assign get_1_pic_done     = force_g  | (in_cnt == N);
  assign conv_1_filter_done = force_cd | (out_cnt == M);

  // Expected per-cycle behaviour relative to the start cycle (cycle 0)
  task automatic build_model(input bit fcd, output int s, output int last);
    int a, c, d;
    for (int i = 0; i < MAXC; i++) begin
      e_prdy[i] = 0; e_vin[i] = 0; e_pp1[i] = 0; e_oe[i] = 0; e_pp2[i] = 0;
      e_ov[i] = 0; e_busy[i] = 0; e_done[i] = 0; e_err[i] = 0;
    end
    a = 0;
    c = 1;
    while (a < N) begin
      e_prdy[c] = 1; e_vin[c] = pv[c]; e_pp1[c] = 1; e_busy[c] = 1;
      if (pv[c]) a++;
      c++;
    end
    s = c;
    for (int k = 0; k < N; k++) begin
      e_vin[s+k] = 1;
      e_busy[s+k] = 1;
      if ((k / W) >= 2 && (k % W) >= 2) begin
        e_oe[s+k+L] = 1;
        e_pp2[s+k+L] = 1;
      end
    end
    for (int f = 0; f < L; f++) e_busy[s+N+f] = 1;
    d = s + N + L;
    c = d;
    a = 0;
    while (a < M) begin
      e_busy[c] = 1;
      if (rdy[c]) begin
        e_oe[c] = 1;
        e_ov[c+1] = 1;
        a++;
      end
      c++;
    end
    e_busy[c] = 1;
    e_busy[c+1] = 1;
    e_done[c+1] = 1;
    last = c + 2;
    for (int i = d; i < MAXC; i++) e_err[i] = fcd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; start = 0; pixel_valid_i = 0; ready_i = 0; force_g = 0; force_cd = 0;
    @(negedge clk);
    reset = 0;
  endtask

  // One image from start, compared cycle by cycle against the model
  task automatic run_image(input string name, input bit hold, input bit fcd, input int abort_off);
    int s, last, abt, n_ov, n_done;
    logic [7:0] got, exp;
    build_model(fcd, s, last);
    abt = (abort_off > 0) ? s + abort_off : -1;
    if (hold) begin
      e_prdy[last+1] = 1; e_vin[last+1] = pv[last+1]; e_pp1[last+1] = 1; e_busy[last+1] = 1;
    end
    n_ov = 0;
    n_done = 0;
    for (int c = 0; c <= last + (hold ? 1 : 0); c++) begin
      @(negedge clk);
      reset = (c == abt);
      start = (c == 0) || hold;
      pixel_valid_i = pv[c];
      ready_i = rdy[c];
      force_cd = fcd;
      #1;
      got = {pixel_ready_o, valid_in, pp1, oe, pp2, out_valid, busy, done};
      if (abt >= 0 && c == abt + 1) begin
        n_checks++;
        if ({got, err} !== 9'b0)
          $display("FAIL %s post_reset cycle %0d: got %b err %b expected all 0", name, c, got, err);
        else n_pass++;
        break;
      end
      if (c != abt) begin
        exp = {e_prdy[c], e_vin[c], e_pp1[c], e_oe[c], e_pp2[c], e_ov[c], e_busy[c], e_done[c]};
        n_checks++;
        if (got !== exp)
          $display("FAIL %s cycle %0d: {prdy,vin,pp1,oe,pp2,ov,busy,done} got %b expected %b",
                   name, c, got, exp);
        else n_pass++;
        if (c >= 1) begin
          n_checks++;
          if (err !== e_err[c]) $display("FAIL %s err cycle %0d: got %b expected %b", name, c, err, e_err[c]);
          else n_pass++;
        end
        n_ov += int'(out_valid);
        n_done += int'(done);
      end
    end
    if (abt < 0) begin
      n_checks++;
      if (n_ov !== M || n_done !== 1)
        $display("FAIL %s totals: out_valid %0d done %0d expected %0d and 1", name, n_ov, n_done, M);
      else n_pass++;
    end
    force_cd = 0;
  endtask

  task automatic test_reset();
    reset = 1; start = 0; pixel_valid_i = 1; ready_i = 1; force_g = 0; force_cd = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if ({pixel_ready_o, valid_in, pp1, oe, pp2, out_valid, busy, done, err} !== 9'b0)
      $display("FAIL reset_state: got %b expected 0",
               {pixel_ready_o, valid_in, pp1, oe, pp2, out_valid, busy, done, err});
    else n_pass++;
    reset = 0;
    @(negedge clk);
    #1;
    n_checks++;
    if ({pixel_ready_o, valid_in, pp1, busy} !== 4'b0)
      $display("FAIL idle_ignores_pixels: got %b expected 0", {pixel_ready_o, valid_in, pp1, busy});
    else n_pass++;
    pixel_valid_i = 0;
  endtask

  task automatic fill(input int pmode, input int rmode);
    for (int c = 0; c < MAXC; c++) begin
      case (pmode)
        0:       pv[c] = 1;
        1:       pv[c] = (c % 2) == 1;
        default: pv[c] = (c % 4 == 0) ? 1'b1 : 1'(($urandom_range(0, 1)));
      endcase
      case (rmode)
        0:       rdy[c] = 1;
        1:       rdy[c] = (c % 4) < 2;
        default: rdy[c] = (c % 4 == 0) ? 1'b1 : 1'(($urandom_range(0, 1)));
      endcase
    end
  endtask

  task automatic test_continuous();
    fill(0, 0);
    run_image("continuous", 0, 0, 0);
  endtask

  task automatic test_toggle_pixels();
    fill(1, 0);
    run_image("toggle_pixels", 0, 0, 0);
  endtask

  task automatic test_ready_pattern();
    fill(0, 1);
    run_image("ready_1100", 0, 0, 0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      fill(2, 2);
      run_image("random", 0, 0, 0);
    end
  endtask

  task automatic test_load_err();
    for (int c = 0; c <= 14; c++) begin
      @(negedge clk);
      start = (c == 0) || (c == 13);
      pixel_valid_i = (c != 11);
      force_g = (c == 11);
      ready_i = 0;
      #1;
      if (c == 11) begin
        n_checks++;
        if ({pixel_ready_o, err} !== 2'b10) $display("FAIL load_err_pre: got %b expected 10", {pixel_ready_o, err});
        else n_pass++;
      end
      if (c == 12) begin
        n_checks++;
        if ({busy, pixel_ready_o, valid_in, err} !== 4'b0001)
          $display("FAIL load_err_abort: got %b expected 0001", {busy, pixel_ready_o, valid_in, err});
        else n_pass++;
      end
      if (c == 13) begin
        n_checks++;
        if ({busy, err} !== 2'b01) $display("FAIL load_err_sticky: got %b expected 01", {busy, err});
        else n_pass++;
      end
      if (c == 14) begin
        n_checks++;
        if ({err, busy, pixel_ready_o} !== 3'b011)
          $display("FAIL load_err_clear: got %b expected 011", {err, busy, pixel_ready_o});
        else n_pass++;
      end
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    fill(2, 0);
    run_image("reset_mid_stream", 0, 0, 10);
    fill(0, 0);
    run_image("after_reset", 0, 0, 0);
  endtask

  task automatic test_flush_err();
    fill(0, 0);
    run_image("flush_flag_err", 0, 1, 0);
    run_image("err_cleared", 0, 0, 0);
  endtask

  task automatic test_start_held();
    fill(0, 0);
    run_image("start_held", 1, 0, 0);
    do_reset();
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_toggle_pixels();
    test_ready_pattern();
    test_random();
    test_load_err();
    test_reset_mid();
    test_flush_err();
    test_start_held();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
